id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Issue/hazard controller between decode and execute in the 5-stage RV64 pipe (IF/ID/EX/MEM/WB).
//  Tracks in-flight destinations, selects forwarding, stalls on load-use, serialises SYSTEM/FENCE,
//  and flushes IF/ID on an EX-resolved branch or jump.
// PARAMETERS
//  XLEN    64  datapath width (redirect target)
//  FWD_EN  1   1: EX/MEM/WB forwarding, stall only on load-use; 0: stall until producer leaves WB
// PORTS
//  clk              in   1     clock, rising edge
//  rst_n            in   1     asynchronous, active-low reset
//  id_valid         in   1     ID holds a valid decoded instruction
//  id_rs1_ena       in   1     rs1 read enable from decode
//  id_rs1_addr      in   5     rs1 index
//  id_rs2_ena       in   1     rs2 read enable
//  id_rs2_addr      in   5     rs2 index
//  id_rd_ena        in   1     rd write enable
//  id_rd_addr       in   5     rd index
//  id_mem_to_reg    in   1     instruction is a load
//  id_serialize     in   1     SYSTEM or FENCE/FENCE.I opcode
//  mem_stall        in   1     memory busy; EX/MEM/WB frozen
//  ex_redirect      in   1     EX resolved taken branch/JAL/JALR
//  ex_target        in   XLEN  redirect PC
//  id_issue         out  1     ID instruction enters EX this cycle
//  id_stall         out  1     hold ID register
//  if_stall         out  1     hold PC and IF/ID
//  if_flush         out  1     kill IF/ID contents
//  id_flush         out  1     insert bubble into EX
//  pc_redirect      out  1     load PC with pc_redirect_addr
//  pc_redirect_addr out  XLEN  = ex_target while pc_redirect, else 0
//  fwd_rs1_sel      out  2     00 regfile, 01 EX, 10 MEM, 11 WB
//  fwd_rs2_sel      out  2     as fwd_rs1_sel
// BEHAVIOUR
//  Reset: all outputs 0; scoreboard slots cleared; FSM=RUN; serial counter 0.
//  Scoreboard: slots EX,MEM,WB each {occ,wr,rd,ld}. If mem_stall=0: WB<=MEM, MEM<=EX,
//   EX<=id_issue ? {1, id_rd_ena&(rd!=0), id_rd_addr, id_mem_to_reg} : 0. If mem_stall=1: hold all.
//  match(S,rs) = S.wr & rs_ena & (rs!=0) & (rs==S.rd). Priority EX > MEM > WB.
//  FWD_EN=1: sel = code of first matching slot; raw_hz = match(EX) & EX.ld for either source.
//  FWD_EN=0: sel=00 always; raw_hz = any match in EX, MEM or WB.
//  FSM:
//   RUN:    id_serialize & id_valid & any slot occ -> stall, go DRAIN;
//           id_serialize & pipe empty & issue -> SERIAL, cnt=3.
//   DRAIN:  stall; when all occ=0 and no raw_hz, issue -> SERIAL, cnt=3.
//   SERIAL: stall every ID instruction; cnt-- per cycle with mem_stall=0; cnt==0 -> RUN.
//   ex_redirect (accepted) in any state -> RUN, cnt=0.
//  id_stall = if_stall = id_valid & (raw_hz | mem_stall | FSM blocks) & ~redirect_acc.
//  redirect_acc = ex_redirect & ~mem_stall; ex_redirect is ignored while mem_stall=1
//   (EX held, so it is re-presented).
//  redirect_acc -> same cycle (comb): pc_redirect=1, if_flush=1, id_flush=1, id_issue=0.
//  id_issue = id_valid & ~id_stall & ~redirect_acc & ~mem_stall.
//  id_flush is also 1 whenever mem_stall=0 and ID stalls (bubble into EX).
//  Flush beats stall; mem_stall beats everything except reset.
//  Async reset mid-operation: slots and FSM clear immediately; no pending redirect survives.
// STRUCTURE
//  defines.v: FSM codes ICTL_RUN/DRAIN/SERIAL, FWD_SEL_RF/EX/MEM/WB, SLOT_BUS width.
//  Sub-module issue_scoreboard: 3-slot shift tracker + match/priority logic, outputs sel and raw_hz.
//  Top: FSM, serial counter, stall/flush/redirect glue.
// TESTING
//  ld x5 then add x6,x5,x1 -> 1 cycle id_stall, bubble; then fwd_rs1_sel=01 then 10 (FWD_EN=1).
//  addi x5 then add x7,x5,x5 -> no stall, fwd_rs1_sel=fwd_rs2_sel=01; rd=x0 never forwards.
//  FWD_EN=0, addi x5 then use x5 -> 3 stall cycles, sel=00 on issue.
//  beq taken with ex_target=0x80000100 -> pc_redirect=1, addr=0x80000100, if/id_flush=1, no issue.
//  csrrw behind 2 ALU ops -> DRAIN 2 cycles, issue, SERIAL 3 cycles, next inst issues cycle 6.
//  ex_redirect with mem_stall=1 for 4 cycles -> pc_redirect only in cycle mem_stall drops; reset mid-DRAIN -> RUN, outputs 0.

Source files
------------

// File: rtl/id_issue_ctrl_pkg.sv
// rtl/id_issue_ctrl_pkg.sv - shared types and constants for the ID issue controller
//
// Purpose : FSM state codes, forwarding select codes, scoreboard slot layout
//           and the source/slot match helper used by the scoreboard.
// Ports   : none (package)
package id_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    ICTL_RUN    = 2'd0,
    ICTL_DRAIN  = 2'd1,
    ICTL_SERIAL = 2'd2
  } ictl_state_t;

  localparam logic [1:0] FWD_SEL_RF  = 2'b00;
  localparam logic [1:0] FWD_SEL_EX  = 2'b01;
  localparam logic [1:0] FWD_SEL_MEM = 2'b10;
  localparam logic [1:0] FWD_SEL_WB  = 2'b11;

  // Number of stall cycles a serialising instruction imposes after it issues.
  localparam logic [1:0] SERIAL_CYCLES = 2'd3;

  // Slot layout: {occ, wr, rd[4:0], ld}
  localparam int SLOT_BUS = 8;

  typedef struct packed {
    logic       occ;
    logic       wr;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  // A slot supplies a source only if it writes a non-zero register that the
  // source actually reads; x0 is never a forwarding target.
  function automatic logic slot_match(input slot_t s, input logic ena, input logic [4:0] rs);
    return s.wr & ena & (rs != 5'd0) & (rs == s.rd);
  endfunction

endpackage

// File: rtl/id_issue_ctrl_scoreboard.sv
// rtl/id_issue_ctrl_scoreboard.sv - 3-slot in-flight destination tracker with forwarding select
//
// Purpose : Shifts issued-instruction descriptors through EX/MEM/WB slots and
//           derives forwarding selects and the RAW hazard for the ID sources.
// Ports   : i_clk, i_rst_n        clock, async active-low reset
//           i_advance             1 = pipe moves (memory not stalling)
//           i_issue               ID instruction enters EX this cycle
//           i_rd_ena/i_rd_addr    destination of the issuing instruction
//           i_mem_to_reg          issuing instruction is a load
//           i_rs1_*/i_rs2_*       ID source operands
//           o_fwd_rs1/rs2_sel     forwarding source code
//           o_raw_hz              unresolvable read-after-write hazard
//           o_any_occ             any slot holds an instruction
module id_issue_ctrl_scoreboard
  import id_issue_ctrl_pkg::*;
#(
  parameter bit FWD_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_advance,
  input  logic       i_issue,
  input  logic       i_rd_ena,
  input  logic [4:0] i_rd_addr,
  input  logic       i_mem_to_reg,
  input  logic       i_rs1_ena,
  input  logic [4:0] i_rs1_addr,
  input  logic       i_rs2_ena,
  input  logic [4:0] i_rs2_addr,
  output logic [1:0] o_fwd_rs1_sel,
  output logic [1:0] o_fwd_rs2_sel,
  output logic       o_raw_hz,
  output logic       o_any_occ
);

  slot_t r_ex;
  slot_t r_mem;
  slot_t r_wb;

  logic [SLOT_BUS-1:0] w_ex_nxt;
  logic w_m1_ex, w_m1_mem, w_m1_wb;
  logic w_m2_ex, w_m2_mem, w_m2_wb;

  // A write to x0 is tracked for occupancy but never marked as a writer.
  assign w_ex_nxt = i_issue ? {1'b1, i_rd_ena & (i_rd_addr != 5'd0), i_rd_addr, i_mem_to_reg}
                            : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (i_advance) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= slot_t'(w_ex_nxt);
    end
  end

  assign w_m1_ex  = slot_match(r_ex,  i_rs1_ena, i_rs1_addr);
  assign w_m1_mem = slot_match(r_mem, i_rs1_ena, i_rs1_addr);
  assign w_m1_wb  = slot_match(r_wb,  i_rs1_ena, i_rs1_addr);
  assign w_m2_ex  = slot_match(r_ex,  i_rs2_ena, i_rs2_addr);
  assign w_m2_mem = slot_match(r_mem, i_rs2_ena, i_rs2_addr);
  assign w_m2_wb  = slot_match(r_wb,  i_rs2_ena, i_rs2_addr);

  // Youngest producer wins so the most recent value of the register is used.
  function automatic logic [1:0] pick_sel(input logic ex, input logic mem, input logic wb);
    if (ex)       return FWD_SEL_EX;
    else if (mem) return FWD_SEL_MEM;
    else if (wb)  return FWD_SEL_WB;
    else          return FWD_SEL_RF;
  endfunction

  always_comb begin
    o_fwd_rs1_sel = FWD_SEL_RF;
    o_fwd_rs2_sel = FWD_SEL_RF;
    o_raw_hz      = 1'b0;
    if (FWD_EN) begin
      o_fwd_rs1_sel = pick_sel(w_m1_ex, w_m1_mem, w_m1_wb);
      o_fwd_rs2_sel = pick_sel(w_m2_ex, w_m2_mem, w_m2_wb);
      // Load data only exists from MEM onward, so a load in EX cannot forward.
      o_raw_hz      = (w_m1_ex | w_m2_ex) & r_ex.ld;
    end else begin
      o_raw_hz = w_m1_ex | w_m1_mem | w_m1_wb | w_m2_ex | w_m2_mem | w_m2_wb;
    end
  end

  assign o_any_occ = r_ex.occ | r_mem.occ | r_wb.occ;

endmodule

// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - decode-to-execute issue, hazard and redirect controller
//
// Purpose : Decides each cycle whether the ID instruction issues, stalls or is
//           flushed; serialises SYSTEM/FENCE; applies EX-resolved redirects.
// Ports   : i_clk, i_rst_n            clock, async active-low reset
//           i_id_*                    decoded ID instruction fields
//           i_mem_stall               memory busy, EX/MEM/WB frozen
//           i_ex_redirect/i_ex_target taken branch/jump from EX and its target
//           o_id_issue                ID instruction enters EX
//           o_id_stall/o_if_stall     hold ID / hold PC and IF/ID
//           o_if_flush/o_id_flush     kill IF/ID / bubble into EX
//           o_pc_redirect(_addr)      load PC with target
//           o_fwd_rs1_sel/rs2_sel     00 RF, 01 EX, 10 MEM, 11 WB
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_id_valid,
  input  logic            i_id_rs1_ena,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic            i_id_rs2_ena,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic            i_id_rd_ena,
  input  logic [4:0]      i_id_rd_addr,
  input  logic            i_id_mem_to_reg,
  input  logic            i_id_serialize,
  input  logic            i_mem_stall,
  input  logic            i_ex_redirect,
  input  logic [XLEN-1:0] i_ex_target,
  output logic            o_id_issue,
  output logic            o_id_stall,
  output logic            o_if_stall,
  output logic            o_if_flush,
  output logic            o_id_flush,
  output logic            o_pc_redirect,
  output logic [XLEN-1:0] o_pc_redirect_addr,
  output logic [1:0]      o_fwd_rs1_sel,
  output logic [1:0]      o_fwd_rs2_sel
);

  ictl_state_t r_state;
  ictl_state_t w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;

  logic w_raw_hz;
  logic w_any_occ;
  logic w_redirect_acc;
  logic w_fsm_block;
  logic w_stall;
  logic w_issue;

  id_issue_ctrl_scoreboard #(
    .FWD_EN (FWD_EN)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_advance     (~i_mem_stall),
    .i_issue       (w_issue),
    .i_rd_ena      (i_id_rd_ena),
    .i_rd_addr     (i_id_rd_addr),
    .i_mem_to_reg  (i_id_mem_to_reg),
    .i_rs1_ena     (i_id_rs1_ena),
    .i_rs1_addr    (i_id_rs1_addr),
    .i_rs2_ena     (i_id_rs2_ena),
    .i_rs2_addr    (i_id_rs2_addr),
    .o_fwd_rs1_sel (o_fwd_rs1_sel),
    .o_fwd_rs2_sel (o_fwd_rs2_sel),
    .o_raw_hz      (w_raw_hz),
    .o_any_occ     (w_any_occ)
  );

  // While memory stalls, EX is frozen and will present the redirect again.
  assign w_redirect_acc = i_ex_redirect & ~i_mem_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ICTL_RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fsm_block = 1'b0;

    case (r_state)
      ICTL_RUN:    w_fsm_block = i_id_serialize & w_any_occ;
      ICTL_DRAIN:  w_fsm_block = w_any_occ | w_raw_hz;
      ICTL_SERIAL: w_fsm_block = 1'b1;
      default:     w_fsm_block = 1'b1;
    endcase

    w_stall = i_id_valid & (w_raw_hz | i_mem_stall | w_fsm_block) & ~w_redirect_acc;
    w_issue = i_id_valid & ~w_stall & ~w_redirect_acc & ~i_mem_stall;

    case (r_state)
      ICTL_RUN: begin
        if (i_id_valid & i_id_serialize & w_any_occ) begin
          w_state_nxt = ICTL_DRAIN;
        end else if (i_id_serialize & w_issue) begin
          w_state_nxt = ICTL_SERIAL;
          w_cnt_nxt   = SERIAL_CYCLES;
        end
      end
      ICTL_DRAIN: begin
        if (w_issue) begin
          w_state_nxt = ICTL_SERIAL;
          w_cnt_nxt   = SERIAL_CYCLES;
        end
      end
      ICTL_SERIAL: begin
        // Count only cycles in which the pipe actually advances; leave on the
        // cycle the count reaches zero so SERIAL lasts exactly SERIAL_CYCLES.
        if (!i_mem_stall) begin
          if (r_cnt <= 2'd1) begin
            w_state_nxt = ICTL_RUN;
            w_cnt_nxt   = 2'd0;
          end else begin
            w_cnt_nxt = r_cnt - 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ICTL_RUN;
        w_cnt_nxt   = 2'd0;
      end
    endcase

    // A redirect squashes whatever ID held, including a pending serialiser.
    if (w_redirect_acc) begin
      w_state_nxt = ICTL_RUN;
      w_cnt_nxt   = 2'd0;
    end
  end

  assign o_id_issue         = w_issue;
  assign o_id_stall         = w_stall;
  assign o_if_stall         = w_stall;
  assign o_if_flush         = w_redirect_acc;
  assign o_id_flush         = w_redirect_acc | (~i_mem_stall & w_stall);
  assign o_pc_redirect      = w_redirect_acc;
  assign o_pc_redirect_addr = w_redirect_acc ? i_ex_target : '0;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb/tb_id_issue_ctrl.sv - randomized scoreboard bench for id_issue_ctrl (FWD_EN=1 and 0)
module tb_id_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid, rs1_ena, rs2_ena, rd_ena, mem_to_reg, serialize;
  logic [4:0]  rs1, rs2, rd;
  logic        mem_stall, ex_redirect;
  logic [63:0] ex_target;

  logic [1:0]  issue, id_stall, if_stall, if_flush, id_flush, redir;
  logic [63:0] addr [2];
  logic [1:0]  s1 [2];
  logic [1:0]  s2 [2];

  always #5 clk = ~clk;

  id_issue_ctrl #(.XLEN(64), .FWD_EN(1'b1)) u_fwd (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1_ena(rs1_ena), .i_id_rs1_addr(rs1), .i_id_rs2_ena(rs2_ena), .i_id_rs2_addr(rs2),
    .i_id_rd_ena(rd_ena), .i_id_rd_addr(rd), .i_id_mem_to_reg(mem_to_reg),
    .i_id_serialize(serialize), .i_mem_stall(mem_stall), .i_ex_redirect(ex_redirect),
    .i_ex_target(ex_target), .o_id_issue(issue[0]), .o_id_stall(id_stall[0]),
    .o_if_stall(if_stall[0]), .o_if_flush(if_flush[0]), .o_id_flush(id_flush[0]),
    .o_pc_redirect(redir[0]), .o_pc_redirect_addr(addr[0]),
    .o_fwd_rs1_sel(s1[0]), .o_fwd_rs2_sel(s2[0]));

  id_issue_ctrl #(.XLEN(64), .FWD_EN(1'b0)) u_nofwd (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
    .i_id_rs1_ena(rs1_ena), .i_id_rs1_addr(rs1), .i_id_rs2_ena(rs2_ena), .i_id_rs2_addr(rs2),
    .i_id_rd_ena(rd_ena), .i_id_rd_addr(rd), .i_id_mem_to_reg(mem_to_reg),
    .i_id_serialize(serialize), .i_mem_stall(mem_stall), .i_ex_redirect(ex_redirect),
    .i_ex_target(ex_target), .o_id_issue(issue[1]), .o_id_stall(id_stall[1]),
    .o_if_stall(if_stall[1]), .o_if_flush(if_flush[1]), .o_id_flush(id_flush[1]),
    .o_pc_redirect(redir[1]), .o_pc_redirect_addr(addr[1]),
    .o_fwd_rs1_sel(s1[1]), .o_fwd_rs2_sel(s2[1]));

  // Reference model: every issued instruction is remembered with its age
  // (advancing cycles since it entered EX); it leaves after three advances.
  typedef struct packed {
    logic       v;
    logic       wr;
    logic [4:0] rd;
    logic       ld;
    logic [1:0] age;
  } ent_t;

  ent_t hist [2][3];
  bit   ser_wait [2];
  int   ser_left [2];

  logic [73:0] q0 [$];
  logic [73:0] q1 [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic int newest(input int k, input logic en, input logic [4:0] rs);
    int best;
    best = -1;
    if (!en || rs == 5'd0) return -1;
    for (int i = 0; i < 3; i++)
      if (hist[k][i].v && hist[k][i].wr && hist[k][i].rd == rs &&
          (best < 0 || int'(hist[k][i].age) < best))
        best = int'(hist[k][i].age);
    return best;
  endfunction

  function automatic bit youngest_is_load(input int k);
    for (int i = 0; i < 3; i++)
      if (hist[k][i].v && hist[k][i].age == 2'd0) return hist[k][i].ld;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ser_wait[k] = 1'b0;
      ser_left[k] = 0;
      for (int i = 0; i < 3; i++) hist[k][i] = '0;
    end
  endtask

  task automatic model_step(input int k, input bit fwd, output logic [73:0] e, output bit iss);
    int p1, p2, slot;
    bit busy, hz, blk, st, racc, fl;
    logic [1:0] e1, e2;
    busy = 1'b0;
    for (int i = 0; i < 3; i++) busy |= hist[k][i].v;
    p1 = newest(k, rs1_ena, rs1);
    p2 = newest(k, rs2_ena, rs2);
    if (fwd) begin
      e1 = (p1 < 0) ? 2'd0 : 2'(p1 + 1);
      e2 = (p2 < 0) ? 2'd0 : 2'(p2 + 1);
      hz = (p1 == 0 || p2 == 0) && youngest_is_load(k);
    end else begin
      e1 = 2'd0;
      e2 = 2'd0;
      hz = (p1 >= 0) || (p2 >= 0);
    end
    racc = ex_redirect && !mem_stall;
    blk  = (ser_left[k] > 0) || (busy && (ser_wait[k] || serialize));
    st   = id_valid && (hz || mem_stall || blk) && !racc;
    iss  = id_valid && !st && !racc && !mem_stall;
    fl   = racc || (!mem_stall && st);
    e    = {iss, st, st, racc, fl, racc, (racc ? ex_target : 64'd0), e1, e2};

    if (racc) begin
      ser_wait[k] = 1'b0;
      ser_left[k] = 0;
    end else if (ser_left[k] > 0) begin
      if (!mem_stall) ser_left[k] = ser_left[k] - 1;
    end else if (ser_wait[k]) begin
      if (iss) begin
        ser_wait[k] = 1'b0;
        ser_left[k] = 3;
      end
    end else if (id_valid && serialize && busy) begin
      ser_wait[k] = 1'b1;
    end else if (serialize && iss) begin
      ser_left[k] = 3;
    end

    if (!mem_stall) begin
      for (int i = 0; i < 3; i++)
        if (hist[k][i].v) begin
          if (hist[k][i].age == 2'd2) hist[k][i].v = 1'b0;
          else hist[k][i].age = hist[k][i].age + 2'd1;
        end
      if (iss) begin
        slot = 0;
        for (int i = 2; i >= 0; i--) if (!hist[k][i].v) slot = i;
        hist[k][slot].v   = 1'b1;
        hist[k][slot].wr  = rd_ena && (rd != 5'd0);
        hist[k][slot].rd  = rd;
        hist[k][slot].ld  = mem_to_reg;
        hist[k][slot].age = 2'd0;
      end
    end
  endtask

  task automatic zero_inputs();
    id_valid = 0; rs1_ena = 0; rs2_ena = 0; rd_ena = 0; mem_to_reg = 0; serialize = 0;
    rs1 = 0; rs2 = 0; rd = 0; mem_stall = 0; ex_redirect = 0; ex_target = 64'd0;
  endtask

  function automatic logic [73:0] got_vec(input int k);
    return {issue[k], id_stall[k], if_stall[k], if_flush[k], id_flush[k], redir[k],
            addr[k], s1[k], s2[k]};
  endfunction

  // Monitor: compares whatever the DUTs present against the queued expectations.
  initial begin
    logic [73:0] e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0 && q1.size() > 0) begin
        e = q0.pop_front();
        checks++;
        if (got_vec(0) !== e) begin
          failures++;
          $display("FAIL outputs_fwd cyc=%0d got=%h exp=%h", cyc, got_vec(0), e);
        end
        e = q1.pop_front();
        checks++;
        if (got_vec(1) !== e) begin
          failures++;
          $display("FAIL outputs_nofwd cyc=%0d got=%h exp=%h", cyc, got_vec(1), e);
        end
      end
    end
  end

  initial begin
    logic [73:0] e0, e1;
    bit iss0, iss1, hold, do_rst, drain_rst_done;
    hold = 0;
    drain_rst_done = 0;
    zero_inputs();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      do_rst = (c == 0) || (c % 700 == 699) || (ser_wait[0] && !drain_rst_done && c > 40);
      if (do_rst) begin
        if (c > 40 && ser_wait[0]) drain_rst_done = 1;
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        hold = 0;
        q0.push_back(74'd0);
        q1.push_back(74'd0);
      end else begin
        rst_n = 1'b1;
        if (!hold) begin
          id_valid   = ($urandom_range(0, 99) < 85);
          rs1_ena    = ($urandom_range(0, 99) < 80);
          rs2_ena    = ($urandom_range(0, 99) < 60);
          rd_ena     = ($urandom_range(0, 99) < 75);
          rs1        = 5'($urandom_range(0, 3));
          rs2        = 5'($urandom_range(0, 3));
          rd         = 5'($urandom_range(0, 3));
          mem_to_reg = ($urandom_range(0, 99) < 30);
          serialize  = ($urandom_range(0, 99) < 6);
        end
        mem_stall   = ($urandom_range(0, 99) < 15);
        ex_redirect = ($urandom_range(0, 99) < 7);
        ex_target   = ($urandom_range(0, 3) == 0) ? 64'h0000_0000_8000_0100
                                                  : {$urandom(), $urandom()};
        model_step(0, 1'b1, e0, iss0);
        model_step(1, 1'b0, e1, iss1);
        q0.push_back(e0);
        q1.push_back(e1);
        // ID keeps presenting a stalled instruction until it issues or is flushed.
        hold = id_valid && !iss0 && !(ex_redirect && !mem_stall);
      end
    end
    for (int w = 0; w < 10 && q0.size() > 0; w++) begin
      @(negedge clk);
      #1;
    end
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL drain_queue got=%0d pending exp=0", q0.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
